// File: rtl/op_reg_hist_pkg.sv
// Shared types for the operand/operation capture register.
// Provides the command encoding and the priority decode used by op_reg_hist.
package op_reg_hist_pkg;

  // One command is acted on per clock edge.
  typedef enum logic [1:0] {
    CMD_HOLD  = 2'd0,
    CMD_CLEAR = 2'd1,
    CMD_LOAD  = 2'd2,
    CMD_UNDO  = 2'd3
  } cmd_e;

  // Priority is clear > load > undo > hold.
  // An undo with no saved history degrades to hold, so the datapath never sees
  // a pop of an empty stack.
  function automatic cmd_e decode_cmd(input logic clear, input logic en,
                                      input logic undo, input logic has_hist);
    cmd_e c;
    if (clear) begin
      c = CMD_CLEAR;
    end else if (en) begin
      c = CMD_LOAD;
    end else if (undo && has_hist) begin
      c = CMD_UNDO;
    end else begin
      c = CMD_HOLD;
    end
    return c;
  endfunction

endpackage

// File: rtl/op_reg_hist_if.sv
// Command/data bundle of op_reg_hist.
// master (input stage): drives clear, en, undo, D; reads Q, hist_cnt, hist_full, changed.
// slave  (op_reg_hist): the reverse.
interface op_reg_hist_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 3,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             clear;
  logic             en;
  logic             undo;
  logic [IN_W-1:0]  D;
  logic [OUT_W-1:0] Q;
  logic [CW-1:0]    hist_cnt;
  logic             hist_full;
  logic             changed;

  modport master (output clear, en, undo, D,
                  input  Q, hist_cnt, hist_full, changed);
  modport slave  (input  clear, en, undo, D,
                  output Q, hist_cnt, hist_full, changed);
endinterface

// File: rtl/op_reg_hist_lifo.sv
// hist_lifo: DEPTH-entry shift-register stack with saturating count.
// Ports: clk, rst_n (async, active-low); clr_i, push_i, pop_i (clr > push > pop);
// push_data_i (value pushed onto entry 0); top_o (entry 0); cnt_o (valid entries);
// full_o (cnt_o == DEPTH). A push onto a full stack drops the oldest entry.
module hist_lifo #(
  parameter int             W     = 3,
  parameter int             DEPTH = 4,
  parameter logic [W-1:0]   FILL  = '1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               push_data_i,
  output logic [W-1:0]               top_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       full_o
);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);

  logic [W-1:0]  stk_q [DEPTH];
  logic [W-1:0]  stk_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q;

  // Next-state of the stack and count.
  always_comb begin
    stk_d = stk_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) stk_d[i] = FILL;
      cnt_d = ZERO_C;
    end else if (push_i) begin
      stk_d[0] = push_data_i;
      for (int i = 1; i < DEPTH; i++) stk_d[i] = stk_q[i-1];
      if (cnt_q != DEPTH_C) begin
        cnt_d = cnt_q + ONE_C;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop_i && (cnt_q != ZERO_C)) begin
      for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
      stk_d[DEPTH-1] = FILL;
      cnt_d = cnt_q - ONE_C;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stack, count and full flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= FILL;
      cnt_q  <= ZERO_C;
      full_q <= 1'b0;
    end else begin
      stk_q  <= stk_d;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == DEPTH_C);
    end
  end

  assign top_o  = stk_q[0];
  assign cnt_o  = cnt_q;
  assign full_o = full_q;
endmodule

// File: rtl/op_reg_hist.sv
// op_reg_hist: captures D[LSB+OUT_W-1:LSB] into Q on load and keeps a
// DEPTH-deep undo history of previous Q values.
// Ports: clk, rst_n (async, active-low); bus (slave): clear, en, undo, D in;
// Q, hist_cnt, hist_full, changed out. changed pulses the cycle after Q moved.
module op_reg_hist
  import op_reg_hist_pkg::*;
#(
  parameter int               IN_W    = 5,
  parameter int               OUT_W   = 3,
  parameter int               LSB     = 0,
  parameter logic [OUT_W-1:0] RST_VAL = '1,
  parameter int               DEPTH   = 4
) (
  input logic           clk,
  input logic           rst_n,
  op_reg_hist_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  if ((LSB + OUT_W > IN_W) || (DEPTH < 1)) begin : g_bad_param
    $error("op_reg_hist: field exceeds input word or DEPTH < 1");
  end

  cmd_e             cmd_s;
  logic [OUT_W-1:0] field_s;
  logic [OUT_W-1:0] top_s;
  logic [CW-1:0]    cnt_s;
  logic             full_s;
  logic [OUT_W-1:0] q_q, q_d;
  logic             changed_q;

  assign cmd_s   = decode_cmd(bus.clear, bus.en, bus.undo, cnt_s != CW'(0));
  assign field_s = bus.D[LSB +: OUT_W];

  hist_lifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH),
    .FILL  (RST_VAL)
  ) u_hist (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (cmd_s == CMD_CLEAR),
    .push_i      (cmd_s == CMD_LOAD),
    .pop_i       (cmd_s == CMD_UNDO),
    .push_data_i (q_q),
    .top_o       (top_s),
    .cnt_o       (cnt_s),
    .full_o      (full_s)
  );

  // Next value of the held field.
  always_comb begin
    q_d = q_q;
    case (cmd_s)
      CMD_CLEAR: q_d = RST_VAL;
      CMD_LOAD:  q_d = field_s;
      CMD_UNDO:  q_d = top_s;
      default:   q_d = q_q;
    endcase
  end

  // Held field and change pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= RST_VAL;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= (q_d != q_q);
    end
  end

  assign bus.Q         = q_q;
  assign bus.hist_cnt  = cnt_s;
  assign bus.hist_full = full_s;
  assign bus.changed   = changed_q;
endmodule

// File: tb/tb_op_reg_hist.sv
// Self-checking bench for op_reg_hist (default parameters plus one variant).
module tb_op_reg_hist;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  op_reg_hist_if #(.IN_W(5), .OUT_W(3), .DEPTH(4)) b ();
  op_reg_hist_if #(.IN_W(8), .OUT_W(4), .DEPTH(2)) b2 ();

  op_reg_hist u_dut (.clk(clk), .rst_n(rst_n), .bus(b));

  op_reg_hist #(.IN_W(8), .OUT_W(4), .LSB(4), .RST_VAL(4'h0), .DEPTH(2))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  // Reference model: Q plus a list of saved values, newest first.
  logic [2:0] m_q = 3'b111;
  logic [2:0] m_hist [$];
  logic       m_chg = 1'b0;

  task automatic model_step(input logic c, input logic e, input logic u, input logic [4:0] d);
    logic [2:0] old;
    old = m_q;
    if (c) begin
      m_q = 3'b111;
      m_hist.delete();
    end else if (e) begin
      m_hist.push_front(m_q);
      if (m_hist.size() > 4) void'(m_hist.pop_back());
      m_q = d[2:0];
    end else if (u && m_hist.size() > 0) begin
      m_q = m_hist.pop_front();
    end
    m_chg = (m_q != old);
  endtask

  task automatic model_reset();
    m_q = 3'b111;
    m_hist.delete();
    m_chg = 1'b0;
  endtask

  // Drive one command, take the edge, sample 1 time unit later.
  task automatic step(input logic c, input logic e, input logic u, input logic [4:0] d);
    @(negedge clk);
    b.clear = c; b.en = e; b.undo = u; b.D = d;
    @(posedge clk);
    model_step(c, e, u, d);
    #1;
    b.clear = 1'b0; b.en = 1'b0; b.undo = 1'b0;
  endtask

  task automatic step2(input logic c, input logic e, input logic u, input logic [7:0] d);
    @(negedge clk);
    b2.clear = c; b2.en = e; b2.undo = u; b2.D = d;
    @(posedge clk);
    #1;
    b2.clear = 1'b0; b2.en = 1'b0; b2.undo = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (b.Q !== 3'b111) begin bad++; $display("FAIL reset_q got=%b exp=111", b.Q); end
    total++; if (b.hist_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", b.hist_cnt); end
    total++; if (b.hist_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", b.hist_full); end
    total++; if (b.changed !== 1'b0) begin bad++; $display("FAIL reset_chg got=%b exp=0", b.changed); end
    total++; if (b2.Q !== 4'h0) begin bad++; $display("FAIL reset_q2 got=%h exp=0", b2.Q); end
    step(1'b0, 1'b1, 1'b0, 5'b00010);
    total++; if (b.Q !== 3'b010) begin bad++; $display("FAIL pre_reset_q got=%b exp=010", b.Q); end
    // Asynchronous assertion in the middle of the low phase.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (b.Q !== 3'b111) begin bad++; $display("FAIL async_reset_q got=%b exp=111", b.Q); end
    total++; if (b.hist_cnt !== 3'd0) begin bad++; $display("FAIL async_reset_cnt got=%0d exp=0", b.hist_cnt); end
    total++; if (b.changed !== 1'b0) begin bad++; $display("FAIL async_reset_chg got=%b exp=0", b.changed); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    step(1'b0, 1'b1, 1'b0, 5'b10101);
    total++; if (b.Q !== 3'b101) begin bad++; $display("FAIL load_q got=%b exp=101", b.Q); end
    total++; if (b.hist_cnt !== 3'd1) begin bad++; $display("FAIL load_cnt got=%0d exp=1", b.hist_cnt); end
    total++; if (b.changed !== 1'b1) begin bad++; $display("FAIL load_chg got=%b exp=1", b.changed); end
    step(1'b0, 1'b0, 1'b0, 5'b11101);
    total++; if (b.Q !== 3'b101) begin bad++; $display("FAIL hold_q got=%b exp=101", b.Q); end
    total++; if (b.changed !== 1'b0) begin bad++; $display("FAIL hold_chg got=%b exp=0", b.changed); end
  endtask

  task automatic test_undo_chain();
    logic [2:0] exp_q [3] = '{3'b010, 3'b001, 3'b111};
    step(1'b1, 1'b0, 1'b0, 5'b00000);
    total++; if (b.changed !== 1'b1) begin bad++; $display("FAIL clear_chg got=%b exp=1", b.changed); end
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b0, 5'(i));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 5'b00000);
      total++; if (b.Q !== exp_q[i]) begin bad++; $display("FAIL undo_q[%0d] got=%b exp=%b", i, b.Q, exp_q[i]); end
      total++; if (b.hist_cnt !== 3'(2 - i)) begin bad++; $display("FAIL undo_cnt[%0d] got=%0d exp=%0d", i, b.hist_cnt, 2 - i); end
    end
    step(1'b0, 1'b0, 1'b1, 5'b00000);
    total++; if (b.Q !== 3'b111) begin bad++; $display("FAIL undo_empty_q got=%b exp=111", b.Q); end
    total++; if (b.hist_cnt !== 3'd0) begin bad++; $display("FAIL undo_empty_cnt got=%0d exp=0", b.hist_cnt); end
    total++; if (b.changed !== 1'b0) begin bad++; $display("FAIL undo_empty_chg got=%b exp=0", b.changed); end
  endtask

  task automatic test_overflow();
    logic [2:0] exp_q [4] = '{3'b101, 3'b100, 3'b011, 3'b010};
    step(1'b1, 1'b0, 1'b0, 5'b00000);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 1'b0, 5'(i));
    total++; if (b.hist_full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", b.hist_full); end
    total++; if (b.hist_cnt !== 3'd4) begin bad++; $display("FAIL ovf_cnt got=%0d exp=4", b.hist_cnt); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 5'b00000);
      total++; if (b.Q !== exp_q[i]) begin bad++; $display("FAIL ovf_undo_q[%0d] got=%b exp=%b", i, b.Q, exp_q[i]); end
      total++; if (b.hist_full !== 1'b0) begin bad++; $display("FAIL ovf_undo_full[%0d] got=%b exp=0", i, b.hist_full); end
    end
    step(1'b0, 1'b0, 1'b1, 5'b00000);
    total++; if (b.Q !== 3'b010) begin bad++; $display("FAIL ovf_noop_q got=%b exp=010", b.Q); end
    total++; if (b.hist_cnt !== 3'd0) begin bad++; $display("FAIL ovf_noop_cnt got=%0d exp=0", b.hist_cnt); end
  endtask

  task automatic test_simultaneous();
    logic [2:0] cnt0;
    cnt0 = b.hist_cnt;
    step(1'b0, 1'b1, 1'b1, 5'b11011);
    total++; if (b.Q !== 3'b011) begin bad++; $display("FAIL en_undo_q got=%b exp=011", b.Q); end
    total++; if (b.hist_cnt !== cnt0 + 3'd1) begin bad++; $display("FAIL en_undo_cnt got=%0d exp=%0d", b.hist_cnt, cnt0 + 3'd1); end
    step(1'b1, 1'b1, 1'b0, 5'b00101);
    total++; if (b.Q !== 3'b111) begin bad++; $display("FAIL clr_en_q got=%b exp=111", b.Q); end
    total++; if (b.hist_cnt !== 3'd0) begin bad++; $display("FAIL clr_en_cnt got=%0d exp=0", b.hist_cnt); end
    total++; if (b.changed !== 1'b1) begin bad++; $display("FAIL clr_en_chg got=%b exp=1", b.changed); end
  endtask

  task automatic test_random();
    logic c, e, u;
    logic [4:0] d;
    for (int n = 0; n < 300; n++) begin
      c = ($urandom_range(15) == 0);
      e = ($urandom_range(7) < 3);
      u = ($urandom_range(7) < 4);
      d = 5'($urandom);
      step(c, e, u, d);
      total++; if (b.Q !== m_q) begin bad++; $display("FAIL rnd_q[%0d] got=%b exp=%b", n, b.Q, m_q); end
      total++; if (b.hist_cnt !== 3'(m_hist.size())) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", n, b.hist_cnt, m_hist.size()); end
      total++; if (b.hist_full !== (m_hist.size() == 4)) begin bad++; $display("FAIL rnd_full[%0d] got=%b", n, b.hist_full); end
      total++; if (b.changed !== m_chg) begin bad++; $display("FAIL rnd_chg[%0d] got=%b exp=%b", n, b.changed, m_chg); end
    end
  endtask

  task automatic test_param_variant();
    logic [7:0] ds [4] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F};
    logic [3:0] eq [4] = '{4'hA, 4'h3, 4'hF, 4'h0};
    logic [1:0] ec [4] = '{2'd1, 2'd2, 2'd2, 2'd2};
    for (int i = 0; i < 4; i++) begin
      step2(1'b0, 1'b1, 1'b0, ds[i]);
      total++; if (b2.Q !== eq[i]) begin bad++; $display("FAIL var_q[%0d] got=%h exp=%h", i, b2.Q, eq[i]); end
      total++; if (b2.hist_cnt !== ec[i]) begin bad++; $display("FAIL var_cnt[%0d] got=%0d exp=%0d", i, b2.hist_cnt, ec[i]); end
      total++; if (b2.changed !== 1'b1) begin bad++; $display("FAIL var_chg[%0d] got=%b exp=1", i, b2.changed); end
    end
    total++; if (b2.hist_full !== 1'b1) begin bad++; $display("FAIL var_full got=%b exp=1", b2.hist_full); end
    step2(1'b0, 1'b0, 1'b1, 8'h00);
    total++; if (b2.Q !== 4'hF) begin bad++; $display("FAIL var_undo_q got=%h exp=F", b2.Q); end
    total++; if (b2.hist_cnt !== 2'd1) begin bad++; $display("FAIL var_undo_cnt got=%0d exp=1", b2.hist_cnt); end
  endtask

  initial begin
    b.clear = 1'b0; b.en = 1'b0; b.undo = 1'b0; b.D = 5'b00000;
    b2.clear = 1'b0; b2.en = 1'b0; b2.undo = 1'b0; b2.D = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_load();
    test_undo_chain();
    test_overflow();
    test_simultaneous();
    test_random();
    test_param_variant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
